// File: rtl/arm_ctrl_pkg.sv
// Shared types for the pipelined ARM control unit.
//   alu_op_e : ALUControl encodings driven into Execute
//   cond_e   : ARM condition-field encodings evaluated in Execute
//   ctrl_t   : decoded control bundle carried from Decode into Execute
//   CTRL_NOP : all-inactive control bundle used for bubbles and undefined ops
package arm_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_ORR = 3'd3,
    ALU_MOV = 3'd4,
    ALU_EOR = 3'd5
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110
  } cond_e;

  typedef struct packed {
    logic [1:0] reg_src;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       br_l;
    logic       no_write;
    logic [1:0] flag_w;      // [1] = NZ, [0] = CV
    alu_op_e    alu_control;
    logic       pcs;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_src:     2'b00,
    imm_src:     2'b00,
    alu_src:     1'b0,
    mem_to_reg:  1'b0,
    reg_w:       1'b0,
    mem_w:       1'b0,
    branch:      1'b0,
    br_l:        1'b0,
    no_write:    1'b0,
    flag_w:      2'b00,
    alu_control: ALU_ADD,
    pcs:         1'b0
  };

endpackage

// File: rtl/cond_unit.sv
// Condition unit for the Execute stage: holds the NZCV flags register,
// evaluates the instruction's cond field against it and gates the
// side-effecting controls of the instruction currently in Execute.
// Ports:
//   clk, rst        clock / asynchronous active-high reset
//   cond            cond field of the instruction in Execute
//   alu_flags       NZCV produced by the ALU this cycle
//   flag_w          flag write enables ([1] NZ, [0] CV)
//   reg_w, no_write, mem_w, pcs, br_l, branch : raw Execute controls
//   cond_ex         condition passed
//   reg_write_g, mem_write_g, pcs_g, link_g, branch_taken : gated controls
module cond_unit
  import arm_ctrl_pkg::*;
#(
  parameter bit         EN_COND  = 1'b1,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       reg_w,
  input  logic       no_write,
  input  logic       mem_w,
  input  logic       pcs,
  input  logic       br_l,
  input  logic       branch,
  output logic       cond_ex,
  output logic       reg_write_g,
  output logic       mem_write_g,
  output logic       pcs_g,
  output logic       link_g,
  output logic       branch_taken
);

  logic [3:0] flags_r;
  logic [3:0] flags_nxt_s;
  logic       cond_met_s;
  logic       cond_ex_s;
  logic       n_s, z_s, c_s, v_s;

  assign {n_s, z_s, c_s, v_s} = flags_r;

  // Condition-field evaluation against the current flags; 1111 never executes.
  always_comb begin
    cond_met_s = 1'b0;
    case (cond)
      COND_EQ: cond_met_s = z_s;
      COND_NE: cond_met_s = ~z_s;
      COND_CS: cond_met_s = c_s;
      COND_CC: cond_met_s = ~c_s;
      COND_MI: cond_met_s = n_s;
      COND_PL: cond_met_s = ~n_s;
      COND_VS: cond_met_s = v_s;
      COND_VC: cond_met_s = ~v_s;
      COND_HI: cond_met_s = c_s & ~z_s;
      COND_LS: cond_met_s = ~c_s | z_s;
      COND_GE: cond_met_s = (n_s == v_s);
      COND_LT: cond_met_s = (n_s != v_s);
      COND_GT: cond_met_s = ~z_s & (n_s == v_s);
      COND_LE: cond_met_s = z_s | (n_s != v_s);
      COND_AL: cond_met_s = 1'b1;
      default: cond_met_s = 1'b0;
    endcase
  end

  // With conditional execution disabled everything behaves as AL.
  always_comb begin
    if (EN_COND) begin
      cond_ex_s = cond_met_s;
    end else begin
      cond_ex_s = 1'b1;
    end
  end

  // Next flags: NZ and CV halves update independently, only when the condition passed.
  always_comb begin
    flags_nxt_s = flags_r;
    if (flag_w[1] && cond_ex_s) begin
      flags_nxt_s[3:2] = alu_flags[3:2];
    end else begin
      flags_nxt_s[3:2] = flags_r[3:2];
    end
    if (flag_w[0] && cond_ex_s) begin
      flags_nxt_s[1:0] = alu_flags[1:0];
    end else begin
      flags_nxt_s[1:0] = flags_r[1:0];
    end
  end

  // NZCV register; written at the edge that ends Execute so the next instruction sees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_r <= FLAG_RST;
    end else begin
      flags_r <= flags_nxt_s;
    end
  end

  assign cond_ex      = cond_ex_s;
  assign reg_write_g  = reg_w & cond_ex_s & ~no_write;
  assign mem_write_g  = mem_w & cond_ex_s;
  assign pcs_g        = pcs & cond_ex_s;
  assign link_g       = br_l & cond_ex_s;
  assign branch_taken = branch & cond_ex_s;

endmodule

// File: rtl/pipe_controller.sv
// Pipelined control unit for the 5-stage ARM core. Decodes InstrD, carries
// the control bundle through the D->E, E->M and M->W registers, applies
// conditional execution in Execute and reports PC-write hazards.
// Ports:
//   clk, reset      clock / asynchronous active-high reset
//   InstrD          Instr[31:12] in Decode (cond, Op, Funct, Rn, Rd)
//   ALUFlagsE       NZCV from the ALU in Execute
//   FlushE          load a bubble into the D->E register at the next edge
//   RegSrcD/ImmSrcD Decode-stage selects (combinational)
//   ALUSrcE, ALUControlE, MemtoRegE, BranchTakenE : Execute-stage controls
//   MemWriteM, RegWriteM                           : Memory-stage controls
//   MemtoRegW, RegWriteW, PCSrcW, LinkW            : Writeback controls
//   PCWrPendingF    a PC-writing instruction is in D, E or M
module pipe_controller
  import arm_ctrl_pkg::*;
#(
  parameter int         ALUC_W   = 3,
  parameter bit         EN_COND  = 1'b1,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [19:0]       InstrD,
  input  logic [3:0]        ALUFlagsE,
  input  logic              FlushE,
  output logic [1:0]        RegSrcD,
  output logic [1:0]        ImmSrcD,
  output logic              ALUSrcE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              BranchTakenE,
  output logic              MemtoRegE,
  output logic              MemWriteM,
  output logic              RegWriteM,
  output logic              MemtoRegW,
  output logic              RegWriteW,
  output logic              PCSrcW,
  output logic              LinkW,
  output logic              PCWrPendingF
);

  logic [3:0] cond_d_s;
  logic [1:0] op_d_s;
  logic [5:0] funct_d_s;
  logic [3:0] rd_d_s;

  assign cond_d_s  = InstrD[19:16];
  assign op_d_s    = InstrD[15:14];
  assign funct_d_s = InstrD[13:8];
  assign rd_d_s    = InstrD[3:0];

  logic    dp_valid_s;
  logic    dp_s_s;
  logic    dp_no_write_s;
  alu_op_e dp_alu_s;
  ctrl_t   ctrl_d_s;

  ctrl_t      ctrl_e_r;
  logic [3:0] cond_e_r;

  logic reg_write_m_r, mem_write_m_r, mem_to_reg_m_r, pcs_m_r, link_m_r;
  logic reg_write_w_r, mem_to_reg_w_r, pcs_w_r, link_w_r;

  logic cond_ex_s, reg_write_g_s, mem_write_g_s, pcs_g_s, link_g_s, branch_taken_s;

  // Data-processing command decode; CMP/TST discard the result and always set flags.
  always_comb begin
    dp_valid_s    = 1'b1;
    dp_no_write_s = 1'b0;
    dp_s_s        = funct_d_s[0];
    dp_alu_s      = ALU_ADD;
    case (funct_d_s[4:1])
      4'b0100: dp_alu_s = ALU_ADD;
      4'b0010: dp_alu_s = ALU_SUB;
      4'b0000: dp_alu_s = ALU_AND;
      4'b1100: dp_alu_s = ALU_ORR;
      4'b1101: dp_alu_s = ALU_MOV;
      4'b0001: dp_alu_s = ALU_EOR;
      4'b1010: begin
        dp_alu_s      = ALU_SUB;
        dp_no_write_s = 1'b1;
        dp_s_s        = 1'b1;
      end
      4'b1000: begin
        dp_alu_s      = ALU_AND;
        dp_no_write_s = 1'b1;
        dp_s_s        = 1'b1;
      end
      default: dp_valid_s = 1'b0;
    endcase
  end

  // Main decode into the control bundle; unsupported encodings become NOPs.
  always_comb begin
    ctrl_d_s = CTRL_NOP;
    case (op_d_s)
      2'b00: begin
        if (dp_valid_s) begin
          ctrl_d_s.alu_src     = funct_d_s[5];
          ctrl_d_s.reg_w       = 1'b1;
          ctrl_d_s.no_write    = dp_no_write_s;
          ctrl_d_s.alu_control = dp_alu_s;
          ctrl_d_s.flag_w      = {dp_s_s,
                                  dp_s_s & ((dp_alu_s == ALU_ADD) || (dp_alu_s == ALU_SUB))};
        end else begin
          ctrl_d_s = CTRL_NOP;
        end
      end
      2'b01: begin
        ctrl_d_s.imm_src = 2'b01;
        ctrl_d_s.alu_src = 1'b1;
        if (funct_d_s[0]) begin
          ctrl_d_s.mem_to_reg = 1'b1;
          ctrl_d_s.reg_w      = 1'b1;
        end else begin
          ctrl_d_s.reg_src = 2'b10;
          ctrl_d_s.mem_w   = 1'b1;
        end
      end
      2'b10: begin
        ctrl_d_s.reg_src = 2'b01;
        ctrl_d_s.imm_src = 2'b10;
        ctrl_d_s.alu_src = 1'b1;
        ctrl_d_s.branch  = 1'b1;
        // BL writes the link register (R14), never the PC through Rd.
        ctrl_d_s.br_l    = funct_d_s[4];
        ctrl_d_s.reg_w   = funct_d_s[4];
      end
      default: ctrl_d_s = CTRL_NOP;
    endcase
    ctrl_d_s.pcs = ((rd_d_s == 4'd15) && ctrl_d_s.reg_w && !ctrl_d_s.no_write && !ctrl_d_s.br_l)
                   || ctrl_d_s.branch;
  end

  // D->E register; a flush turns the captured instruction into a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_e_r <= CTRL_NOP;
      cond_e_r <= 4'b0000;
    end else if (FlushE) begin
      ctrl_e_r <= CTRL_NOP;
      cond_e_r <= cond_d_s;
    end else begin
      ctrl_e_r <= ctrl_d_s;
      cond_e_r <= cond_d_s;
    end
  end

  cond_unit #(
    .EN_COND  (EN_COND),
    .FLAG_RST (FLAG_RST)
  ) u_cond (
    .clk          (clk),
    .rst          (reset),
    .cond         (cond_e_r),
    .alu_flags    (ALUFlagsE),
    .flag_w       (ctrl_e_r.flag_w),
    .reg_w        (ctrl_e_r.reg_w),
    .no_write     (ctrl_e_r.no_write),
    .mem_w        (ctrl_e_r.mem_w),
    .pcs          (ctrl_e_r.pcs),
    .br_l         (ctrl_e_r.br_l),
    .branch       (ctrl_e_r.branch),
    .cond_ex      (cond_ex_s),
    .reg_write_g  (reg_write_g_s),
    .mem_write_g  (mem_write_g_s),
    .pcs_g        (pcs_g_s),
    .link_g       (link_g_s),
    .branch_taken (branch_taken_s)
  );

  // E->M register holds the condition-gated controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_m_r  <= 1'b0;
      mem_write_m_r  <= 1'b0;
      mem_to_reg_m_r <= 1'b0;
      pcs_m_r        <= 1'b0;
      link_m_r       <= 1'b0;
    end else begin
      reg_write_m_r  <= reg_write_g_s;
      mem_write_m_r  <= mem_write_g_s;
      mem_to_reg_m_r <= ctrl_e_r.mem_to_reg;
      pcs_m_r        <= pcs_g_s;
      link_m_r       <= link_g_s;
    end
  end

  // M->W register is a plain copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_w_r  <= 1'b0;
      mem_to_reg_w_r <= 1'b0;
      pcs_w_r        <= 1'b0;
      link_w_r       <= 1'b0;
    end else begin
      reg_write_w_r  <= reg_write_m_r;
      mem_to_reg_w_r <= mem_to_reg_m_r;
      pcs_w_r        <= pcs_m_r;
      link_w_r       <= link_m_r;
    end
  end

  assign RegSrcD      = ctrl_d_s.reg_src;
  assign ImmSrcD      = ctrl_d_s.imm_src;
  assign ALUSrcE      = ctrl_e_r.alu_src;
  assign ALUControlE  = ALUC_W'(ctrl_e_r.alu_control);
  assign MemtoRegE    = ctrl_e_r.mem_to_reg;
  assign BranchTakenE = branch_taken_s;
  assign MemWriteM    = mem_write_m_r;
  assign RegWriteM    = reg_write_m_r;
  assign MemtoRegW    = mem_to_reg_w_r;
  assign RegWriteW    = reg_write_w_r;
  assign PCSrcW       = pcs_w_r;
  assign LinkW        = link_w_r;
  // Raw PCS in Execute (before the condition) keeps fetch stalled conservatively.
  assign PCWrPendingF = ctrl_d_s.pcs | ctrl_e_r.pcs | pcs_m_r;

  // Rn and the Decode-only selects are not needed past Decode in this unit.
  logic unused_s;
  assign unused_s = ^{InstrD[7:4], ctrl_e_r.reg_src, ctrl_e_r.imm_src, cond_ex_s};

endmodule

// File: tb/tb_pipe_controller.sv
module tb_pipe_controller;

  logic        clk;
  logic        reset;
  logic [19:0] InstrD;
  logic [3:0]  ALUFlagsE;
  logic        FlushE;
  logic [1:0]  RegSrcD;
  logic [1:0]  ImmSrcD;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic        BranchTakenE;
  logic        MemtoRegE;
  logic        MemWriteM;
  logic        RegWriteM;
  logic        MemtoRegW;
  logic        RegWriteW;
  logic        PCSrcW;
  logic        LinkW;
  logic        PCWrPendingF;

  int vectors;
  int miscompares;

  // Expected per-instruction behaviour, written by hand for each step.
  typedef struct packed {
    logic [1:0] regsrc;
    logic [1:0] immsrc;
    logic       alusrc;
    logic [2:0] aluc;
    logic       m2r;
    logic       writes;   // register write after NoWrite, before condition
    logic       memw;
    logic       br;
    logic       link;
    logic       pcs;
    logic       cx;       // condition expected to pass in Execute
  } exp_t;

  exp_t eq[$];
  exp_t mq[$];
  exp_t wq[$];

  pipe_controller dut (
    .clk          (clk),
    .reset        (reset),
    .InstrD       (InstrD),
    .ALUFlagsE    (ALUFlagsE),
    .FlushE       (FlushE),
    .RegSrcD      (RegSrcD),
    .ImmSrcD      (ImmSrcD),
    .ALUSrcE      (ALUSrcE),
    .ALUControlE  (ALUControlE),
    .BranchTakenE (BranchTakenE),
    .MemtoRegE    (MemtoRegE),
    .MemWriteM    (MemWriteM),
    .RegWriteM    (RegWriteM),
    .MemtoRegW    (MemtoRegW),
    .RegWriteW    (RegWriteW),
    .PCSrcW       (PCSrcW),
    .LinkW        (LinkW),
    .PCWrPendingF (PCWrPendingF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] mk(input logic [3:0] cond, input logic [1:0] op,
                                     input logic [5:0] funct, input logic [3:0] rd);
    return {cond, op, funct, 4'h0, rd};
  endfunction

  function automatic exp_t x(input logic [1:0] regsrc, input logic [1:0] immsrc,
                             input logic alusrc, input logic [2:0] aluc, input logic m2r,
                             input logic writes, input logic memw, input logic br,
                             input logic link, input logic pcs, input logic cx);
    exp_t r;
    r.regsrc = regsrc; r.immsrc = immsrc; r.alusrc = alusrc; r.aluc = aluc;
    r.m2r = m2r; r.writes = writes; r.memw = memw; r.br = br;
    r.link = link; r.pcs = pcs; r.cx = cx;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic reset_queues();
    eq.delete(); mq.delete(); wq.delete();
    eq.push_back('0);
    repeat (2) mq.push_back('0);
    repeat (3) wq.push_back('0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ALUSrcE"},     {7'd0, ALUSrcE},      8'd0);
    chk({tag, "_ALUControlE"}, {5'd0, ALUControlE},  8'd0);
    chk({tag, "_MemtoRegE"},   {7'd0, MemtoRegE},    8'd0);
    chk({tag, "_BranchTakenE"},{7'd0, BranchTakenE}, 8'd0);
    chk({tag, "_MemWriteM"},   {7'd0, MemWriteM},    8'd0);
    chk({tag, "_RegWriteM"},   {7'd0, RegWriteM},    8'd0);
    chk({tag, "_MemtoRegW"},   {7'd0, MemtoRegW},    8'd0);
    chk({tag, "_RegWriteW"},   {7'd0, RegWriteW},    8'd0);
    chk({tag, "_PCSrcW"},      {7'd0, PCSrcW},       8'd0);
    chk({tag, "_LinkW"},       {7'd0, LinkW},        8'd0);
    chk({tag, "_PCWrPendingF"},{7'd0, PCWrPendingF}, 8'd0);
  endtask

  // One pipeline step: drive D, check D/E/M/W against the scoreboard, then enqueue.
  task automatic step(input string tag, input logic [19:0] instr, input logic [3:0] fl,
                      input logic fe, input exp_t d);
    exp_t e, m, w, p;
    @(negedge clk);
    InstrD = instr; ALUFlagsE = fl; FlushE = fe;
    #1;
    e = eq.pop_front(); m = mq.pop_front(); w = wq.pop_front();
    chk({tag, "_RegSrcD"},      {6'd0, RegSrcD},      {6'd0, d.regsrc});
    chk({tag, "_ImmSrcD"},      {6'd0, ImmSrcD},      {6'd0, d.immsrc});
    chk({tag, "_ALUSrcE"},      {7'd0, ALUSrcE},      {7'd0, e.alusrc});
    chk({tag, "_ALUControlE"},  {5'd0, ALUControlE},  {5'd0, e.aluc});
    chk({tag, "_MemtoRegE"},    {7'd0, MemtoRegE},    {7'd0, e.m2r});
    chk({tag, "_BranchTakenE"}, {7'd0, BranchTakenE}, {7'd0, e.br & e.cx});
    chk({tag, "_MemWriteM"},    {7'd0, MemWriteM},    {7'd0, m.memw & m.cx});
    chk({tag, "_RegWriteM"},    {7'd0, RegWriteM},    {7'd0, m.writes & m.cx});
    chk({tag, "_RegWriteW"},    {7'd0, RegWriteW},    {7'd0, w.writes & w.cx});
    chk({tag, "_MemtoRegW"},    {7'd0, MemtoRegW},    {7'd0, w.m2r});
    chk({tag, "_PCSrcW"},       {7'd0, PCSrcW},       {7'd0, w.pcs & w.cx});
    chk({tag, "_LinkW"},        {7'd0, LinkW},        {7'd0, w.link & w.cx});
    chk({tag, "_PCWrPendingF"}, {7'd0, PCWrPendingF}, {7'd0, d.pcs | e.pcs | (m.pcs & m.cx)});
    p = fe ? exp_t'('0) : d;
    eq.push_back(p); mq.push_back(p); wq.push_back(p);
  endtask

  logic [19:0] nop_i;
  exp_t        nop_x;

  initial begin
    vectors = 0;
    miscompares = 0;
    nop_i = mk(4'hE, 2'b11, 6'h00, 4'h0);
    nop_x = x(2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1; InstrD = nop_i; ALUFlagsE = 4'h0; FlushE = 1'b0;
    #12;
    chk_all_zero("por");
    @(negedge clk);
    reset = 1'b0;
    reset_queues();

    // ADDS R1 then ADDEQ: Z set by ADDS makes ADDEQ execute.
    step("adds",  mk(4'hE, 2'b00, 6'b101001, 4'd1), 4'b0000, 1'b0,
         x(2'b00, 2'b00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    step("addeq", mk(4'h0, 2'b00, 6'b001000, 4'd2), 4'b0100, 1'b0,
         x(2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    // CMP sets N; following BLT taken.
    step("cmp",   mk(4'hE, 2'b00, 6'b010101, 4'd0), 4'b0000, 1'b0,
         x(2'b00, 2'b00, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    step("blt",   mk(4'hB, 2'b10, 6'b100000, 4'd0), 4'b1000, 1'b0,
         x(2'b01, 2'b10, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
    step("bl",    mk(4'hE, 2'b10, 6'b110000, 4'd0), 4'b1111, 1'b0,
         x(2'b01, 2'b10, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    // TST updates NZ only (CV stay 00), so STRNE and BCS are both suppressed.
    step("tst",   mk(4'hE, 2'b00, 6'b110001, 4'd0), 4'b0000, 1'b0,
         x(2'b00, 2'b00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    step("strne", mk(4'h1, 2'b01, 6'b011000, 4'd3), 4'b0111, 1'b0,
         x(2'b10, 2'b01, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    step("bcs",   mk(4'h2, 2'b10, 6'b100000, 4'd0), 4'b1111, 1'b0,
         x(2'b01, 2'b10, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    // LDR R15: PC write pending through D, E, M.
    step("ldrpc", mk(4'hE, 2'b01, 6'b011001, 4'd15), 4'b0000, 1'b0,
         x(2'b00, 2'b01, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    step("nop0",  nop_i, 4'b0000, 1'b0, nop_x);
    step("nop1",  nop_i, 4'b0000, 1'b0, nop_x);
    // SUBS flushed in D; its slot must not touch flags, so BEQ still sees Z=1.
    step("subsf", mk(4'hE, 2'b00, 6'b100101, 4'd5), 4'b1111, 1'b1,
         x(2'b00, 2'b00, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    step("beq",   mk(4'h0, 2'b10, 6'b100000, 4'd0), 4'b0000, 1'b0,
         x(2'b01, 2'b10, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
    // Flush while the taken BEQ sits in Execute.
    step("addf",  mk(4'hE, 2'b00, 6'b001000, 4'd7), 4'b0000, 1'b1,
         x(2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    step("eor",   mk(4'hE, 2'b00, 6'b000010, 4'd6), 4'b0000, 1'b0,
         x(2'b00, 2'b00, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    step("orr",   mk(4'hE, 2'b00, 6'b111000, 4'd8), 4'b0000, 1'b0,
         x(2'b00, 2'b00, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    step("undef", mk(4'hE, 2'b00, 6'b000110, 4'd9), 4'b0000, 1'b0, nop_x);
    step("mov",   mk(4'hE, 2'b00, 6'b111010, 4'd10), 4'b0000, 1'b0,
         x(2'b00, 2'b00, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    step("undefs",mk(4'hE, 2'b00, 6'b000111, 4'd11), 4'b0000, 1'b0, nop_x);
    step("beq2",  mk(4'h0, 2'b10, 6'b100000, 4'd0), 4'b0000, 1'b0,
         x(2'b01, 2'b10, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
    step("nop2",  nop_i, 4'b0000, 1'b0, nop_x);
    // cond 1111 never executes.
    step("bnv",   mk(4'hF, 2'b10, 6'b100000, 4'd0), 4'b0000, 1'b0,
         x(2'b01, 2'b10, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++) step("drain", nop_i, 4'b0000, 1'b0, nop_x);

    // Asynchronous reset while an ADD is in Memory with RegWriteM=1.
    step("addr",  mk(4'hE, 2'b00, 6'b001000, 4'd1), 4'b0000, 1'b0,
         x(2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    step("nop3",  nop_i, 4'b0000, 1'b0, nop_x);
    step("nop4",  nop_i, 4'b0000, 1'b0, nop_x);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    reset_queues();
    // Flags back to 0000: BEQ not taken, BNE taken.
    step("beqr",  mk(4'h0, 2'b10, 6'b100000, 4'd0), 4'b0000, 1'b0,
         x(2'b01, 2'b10, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    step("bner",  mk(4'h1, 2'b10, 6'b100000, 4'd0), 4'b0000, 1'b0,
         x(2'b01, 2'b10, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
    for (int i = 0; i < 4; i++) step("drain2", nop_i, 4'b0000, 1'b0, nop_x);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
